// File: rtl/egress_meta_strip.sv
// Egress stage: drops packets with a zero verdict and strips META_WORDS leading words from
// forwarded ones. Define EGRESS_META_STRIP_STAT_EN to build the fwd/drop/runt packet counters.
module egress_meta_strip #(
  parameter int DATA_W      = 128,
  parameter int META_WORDS  = 1,
  parameter int DFIFO_DEPTH = 256,
  parameter int VFIFO_DEPTH = 64,
  parameter int AF_MARGIN   = 16,
  localparam int BCNT_W     = $clog2(DATA_W/8),
  localparam int PKT_W      = DATA_W + 2 + BCNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_tdma_pkt_wr,
  input  logic [PKT_W-1:0] in_tdma_pkt,
  input  logic             in_tdma_valid_wr,
  input  logic             in_tdma_valid,
  output logic             out_tdma_pkt_almostfull,
  output logic             out_outputctrl_pkt_wr,
  output logic [PKT_W-1:0] out_outputctrl_pkt,
  output logic             out_outputctrl_valid_wr,
  output logic             out_outputctrl_valid,
  input  logic             in_outputctrl_pkt_almostfull,
  output logic [31:0]      stat_fwd_cnt,
  output logic [31:0]      stat_drop_cnt,
  output logic [31:0]      stat_runt_cnt
);
  localparam int DA_W = $clog2(DFIFO_DEPTH);
  localparam int VA_W = $clog2(VFIFO_DEPTH);
  localparam logic [DA_W:0] D_AF_TH = (DA_W+1)'(DFIFO_DEPTH - AF_MARGIN);
  localparam logic [VA_W:0] V_AF_TH = (VA_W+1)'(VFIFO_DEPTH - 4);
  localparam logic [3:0]    META_L  = 4'(META_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_STRIP, S_FWD, S_DROP, S_VOUT} state_t;

  logic [PKT_W-1:0] dmem [DFIFO_DEPTH];
  logic [VFIFO_DEPTH-1:0] vmem_q;
  logic [DA_W:0] dwr_q, dwr_d, drd_q, drd_d, d_used;
  logic [VA_W:0] vwr_q, vwr_d, vrd_q, vrd_d, v_used;
  logic d_empty, d_full, d_push, d_pop;
  logic v_empty, v_full, v_push, v_pop;
  logic [PKT_W-1:0] d_head;
  logic head_tail, v_head, start;

  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic first_q, first_d;
  logic pkt_wr_q, pkt_wr_d, valid_wr_q, valid_wr_d, af_q, af_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;

  assign d_used    = dwr_q - drd_q;
  assign v_used    = vwr_q - vrd_q;
  assign d_empty   = (d_used == '0);
  assign v_empty   = (v_used == '0);
  assign d_full    = (d_used == (DA_W+1)'(DFIFO_DEPTH));
  assign v_full    = (v_used == (VA_W+1)'(VFIFO_DEPTH));
  assign d_push    = in_tdma_pkt_wr & ~d_full;
  assign v_push    = in_tdma_valid_wr & ~v_full;
  assign d_head    = dmem[drd_q[DA_W-1:0]];
  assign head_tail = (d_head[PKT_W-1 -: 2] == 2'b10);
  assign v_head    = vmem_q[vrd_q[VA_W-1:0]];
  assign start     = ~v_empty & ~in_outputctrl_pkt_almostfull;

  always_ff @(posedge clk) begin
    if (d_push) dmem[dwr_q[DA_W-1:0]] <= in_tdma_pkt;
    if (v_push) vmem_q[vwr_q[VA_W-1:0]] <= in_tdma_valid;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    first_d    = first_q;
    d_pop      = 1'b0;
    v_pop      = 1'b0;
    pkt_wr_d   = 1'b0;
    pkt_d      = pkt_q;
    valid_wr_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        v_pop   = 1'b1;
        idx_d   = '0;
        first_d = 1'b1;
        if (!v_head)             state_d = S_DROP;
        else if (META_WORDS > 0) state_d = S_STRIP;
        else                     state_d = S_FWD;
      end
      S_STRIP: if (!d_empty) begin
        d_pop = 1'b1;
        if (head_tail) state_d = S_IDLE;
        else begin
          idx_d = idx_q + 4'd1;
          if (idx_d == META_L) state_d = S_FWD;
        end
      end
      S_FWD: if (!d_empty) begin
        d_pop = 1'b1;
        if (first_q) begin
          // a tail here means nothing survives the strip: swallow it as a runt
          if (head_tail) state_d = S_IDLE;
          else begin
            pkt_wr_d = 1'b1;
            pkt_d    = {2'b01, d_head[PKT_W-3:0]};
            first_d  = 1'b0;
          end
        end else begin
          pkt_wr_d = 1'b1;
          pkt_d    = d_head;
          if (head_tail) state_d = S_VOUT;
        end
      end
      S_DROP: if (!d_empty) begin
        d_pop = 1'b1;
        if (head_tail) state_d = S_IDLE;
      end
      S_VOUT: begin
        valid_wr_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dwr_d = dwr_q + (DA_W+1)'(d_push);
    drd_d = drd_q + (DA_W+1)'(d_pop);
    vwr_d = vwr_q + (VA_W+1)'(v_push);
    vrd_d = vrd_q + (VA_W+1)'(v_pop);
    af_d  = (d_used >= D_AF_TH) | (v_used >= V_AF_TH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      first_q    <= 1'b0;
      dwr_q      <= '0;
      drd_q      <= '0;
      vwr_q      <= '0;
      vrd_q      <= '0;
      pkt_wr_q   <= 1'b0;
      pkt_q      <= '0;
      valid_wr_q <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      dwr_q      <= dwr_d;
      drd_q      <= drd_d;
      vwr_q      <= vwr_d;
      vrd_q      <= vrd_d;
      pkt_wr_q   <= pkt_wr_d;
      pkt_q      <= pkt_d;
      valid_wr_q <= valid_wr_d;
      af_q       <= af_d;
    end
  end

  assign out_tdma_pkt_almostfull = af_q;
  assign out_outputctrl_pkt_wr   = pkt_wr_q;
  assign out_outputctrl_pkt      = pkt_q;
  assign out_outputctrl_valid_wr = valid_wr_q;
  assign out_outputctrl_valid    = valid_wr_q;

`ifdef EGRESS_META_STRIP_STAT_EN
  logic fwd_inc, drop_inc, runt_inc;
  logic [31:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d, runt_cnt_q, runt_cnt_d;

  assign fwd_inc  = (state_q == S_VOUT);
  assign drop_inc = (state_q == S_IDLE) & start & ~v_head;
  assign runt_inc = d_pop & head_tail & ((state_q == S_STRIP) | ((state_q == S_FWD) & first_q));

  always_comb begin
    fwd_cnt_d  = fwd_cnt_q + 32'(fwd_inc);
    drop_cnt_d = drop_cnt_q + 32'(drop_inc);
    runt_cnt_d = runt_cnt_q + 32'(runt_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
      runt_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      runt_cnt_q <= runt_cnt_d;
    end
  end

  assign stat_fwd_cnt  = fwd_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
  assign stat_runt_cnt = runt_cnt_q;
`else
  assign stat_fwd_cnt  = '0;
  assign stat_drop_cnt = '0;
  assign stat_runt_cnt = '0;
`endif
endmodule

// File: tb/tb_egress_meta_strip.sv
// Randomized bench for egress_meta_strip against a packet-level queue model.
module tb_egress_meta_strip;
  localparam int DW = 128, BW = 4, PW = DW + 2 + BW, M = 1;
  localparam int PWB = 64 + 2 + 3;
`ifdef EGRESS_META_STRIP_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, pkt_wr, vwr, vld, ds_af;
  logic [PW-1:0] pkt;
  logic af, o_wr, o_vwr, o_v;
  logic [PW-1:0] o_pkt;
  logic [31:0] s_fwd, s_drop, s_runt;

  logic b_pkt_wr, b_vwr, b_vld, b_ds_af;
  logic [PWB-1:0] b_pkt;
  logic b_af, b_o_wr, b_o_vwr, b_o_v;
  logic [PWB-1:0] b_o_pkt;
  logic [31:0] b_s_fwd, b_s_drop, b_s_runt;

  egress_meta_strip #(.DATA_W(DW), .META_WORDS(M), .DFIFO_DEPTH(256), .VFIFO_DEPTH(64),
                      .AF_MARGIN(16)) u_dut (
    .clk(clk), .reset(reset), .in_tdma_pkt_wr(pkt_wr), .in_tdma_pkt(pkt),
    .in_tdma_valid_wr(vwr), .in_tdma_valid(vld), .out_tdma_pkt_almostfull(af),
    .out_outputctrl_pkt_wr(o_wr), .out_outputctrl_pkt(o_pkt),
    .out_outputctrl_valid_wr(o_vwr), .out_outputctrl_valid(o_v),
    .in_outputctrl_pkt_almostfull(ds_af),
    .stat_fwd_cnt(s_fwd), .stat_drop_cnt(s_drop), .stat_runt_cnt(s_runt));

  egress_meta_strip #(.DATA_W(64), .META_WORDS(0), .DFIFO_DEPTH(16), .VFIFO_DEPTH(8),
                      .AF_MARGIN(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_tdma_pkt_wr(b_pkt_wr), .in_tdma_pkt(b_pkt),
    .in_tdma_valid_wr(b_vwr), .in_tdma_valid(b_vld), .out_tdma_pkt_almostfull(b_af),
    .out_outputctrl_pkt_wr(b_o_wr), .out_outputctrl_pkt(b_o_pkt),
    .out_outputctrl_valid_wr(b_o_vwr), .out_outputctrl_valid(b_o_v),
    .in_outputctrl_pkt_almostfull(b_ds_af),
    .stat_fwd_cnt(b_s_fwd), .stat_drop_cnt(b_s_drop), .stat_runt_cnt(b_s_runt));

  int checks = 0, errors = 0, cyc = 0, vcyc = 0;
  always @(posedge clk) cyc++;

  // observed streams
  logic [PW-1:0] got_q[$];
  int got_cyc[$];
  int vcnt = 0, vbad = 0, last_tail_cyc = -10;
  logic [PWB-1:0] b_got[$];
  int b_vcnt = 0;

  always @(negedge clk) begin
    if (o_wr) begin
      got_q.push_back(o_pkt);
      got_cyc.push_back(cyc);
      if (o_pkt[PW-1 -: 2] == 2'b10) last_tail_cyc = cyc;
    end
    if (o_vwr) begin
      vcnt++;
      if (o_v !== 1'b1 || last_tail_cyc != cyc - 1) vbad++;
    end
    if (b_o_wr) b_got.push_back(b_o_pkt);
    if (b_o_vwr && b_o_v) b_vcnt++;
  end

  // reference model
  logic [PW-1:0] exp_q[$];
  int exp_vcnt = 0, exp_fwd = 0, exp_drop = 0, exp_runt = 0;

  function automatic int stat_exp(input int n);
    return STAT ? n : 0;
  endfunction

  function automatic logic [PW-1:0] mk_word(input int i, input int len, input logic [BW-1:0] tbc);
    logic [DW-1:0] d;
    logic [1:0] f;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    f = (i == len-1) ? 2'b10 : (i == 0) ? 2'b01 : 2'b11;
    return {f, (i == len-1) ? tbc : {BW{1'b0}}, d};
  endfunction

  task automatic model_pkt(input logic [PW-1:0] w[$], input bit verdict);
    logic [PW-1:0] x;
    if (!verdict) exp_drop++;
    else if (w.size() <= M + 1) exp_runt++;
    else begin
      for (int i = M; i < w.size(); i++) begin
        x = w[i];
        if (i == M) x[PW-1 -: 2] = 2'b01;
        exp_q.push_back(x);
      end
      exp_vcnt++;
      exp_fwd++;
    end
  endtask

  task automatic send_pkt(input int len, input bit verdict, input int vdelay, input logic [BW-1:0] tbc);
    logic [PW-1:0] w[$];
    for (int i = 0; i < len; i++) w.push_back(mk_word(i, len, tbc));
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      pkt_wr = 1'b1; pkt = w[i]; vwr = 1'b0;
      if (i == len-1 && vdelay == 0) begin vwr = 1'b1; vld = verdict; vcyc = cyc; end
    end
    for (int d = 1; d <= vdelay; d++) begin
      @(posedge clk); #1;
      pkt_wr = 1'b0; vwr = (d == vdelay); vld = verdict;
      if (d == vdelay) vcyc = cyc;
    end
    @(posedge clk); #1;
    pkt_wr = 1'b0; vwr = 1'b0;
    model_pkt(w, verdict);
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while ((got_q.size() < exp_q.size() || vcnt < exp_vcnt) && n < budget) begin
      @(negedge clk); n++;
    end
    ok = (n < budget);
    repeat (60) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; pkt_wr = 1'b0; vwr = 1'b0; vld = 1'b0; ds_af = 1'b0;
    b_pkt_wr = 1'b0; b_vwr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete(); got_cyc.delete(); exp_q.delete(); b_got.delete();
    vcnt = 0; vbad = 0; exp_vcnt = 0; b_vcnt = 0; last_tail_cyc = -10;
    exp_fwd = 0; exp_drop = 0; exp_runt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pkt_wr = 1'b0; pkt = '0; vwr = 1'b0; vld = 1'b0; ds_af = 1'b0;
    b_pkt_wr = 1'b0; b_pkt = '0; b_vwr = 1'b0; b_vld = 1'b0; b_ds_af = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({o_wr, o_vwr, o_v, af} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {o_wr, o_vwr, o_v, af}); end
    checks++; if (o_pkt !== '0) begin errors++;
      $display("FAIL reset_pkt: got %h expected 0", o_pkt); end
    checks++; if ({s_fwd, s_drop, s_runt} !== 96'd0) begin errors++;
      $display("FAIL reset_stats: got %0d/%0d/%0d expected 0", s_fwd, s_drop, s_runt); end
    checks++; if ({b_o_wr, b_o_vwr, b_af, b_o_pkt} !== '0) begin errors++;
      $display("FAIL reset_b: got %b/%b/%b expected 0", b_o_wr, b_o_vwr, b_af); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_fwd_basic();
    bit ok; int nbad = 0;
    apply_reset();
    send_pkt(4, 1'b1, 0, 4'd5);
    drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_timeout: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL fwd_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL fwd_words: got %0d bad words expected 0", nbad); end
    if (got_q.size() == 3) begin
      checks++; if (got_q[0][PW-1 -: 2] !== 2'b01) begin errors++;
        $display("FAIL fwd_head_flag: got %b expected 01", got_q[0][PW-1 -: 2]); end
      checks++; if (got_q[2][PW-3 -: BW] !== 4'd5) begin errors++;
        $display("FAIL fwd_tail_bcnt: got %0d expected 5", got_q[2][PW-3 -: BW]); end
      checks++; if (got_cyc[0] - vcyc != 3 + M) begin errors++;
        $display("FAIL fwd_latency: got %0d expected %0d", got_cyc[0] - vcyc, 3 + M); end
    end
    checks++; if (vcnt != 1 || vbad != 0) begin errors++;
      $display("FAIL fwd_valid: got %0d strobes (%0d misplaced) expected 1", vcnt, vbad); end
    checks++; if (s_fwd !== stat_exp(exp_fwd)) begin errors++;
      $display("FAIL fwd_stat: got %0d expected %0d", s_fwd, stat_exp(exp_fwd)); end
  endtask

  task automatic test_drop();
    bit ok;
    apply_reset();
    send_pkt(4, 1'b0, 0, 4'd5);
    drain(200, ok);
    checks++; if (got_q.size() != 0 || vcnt != 0) begin errors++;
      $display("FAIL drop_out: got %0d words %0d strobes expected 0", got_q.size(), vcnt); end
    checks++; if (u_dut.d_used !== '0) begin errors++;
      $display("FAIL drop_fifo: got used %0d expected 0", u_dut.d_used); end
    checks++; if (s_drop !== stat_exp(exp_drop)) begin errors++;
      $display("FAIL drop_stat: got %0d expected %0d", s_drop, stat_exp(exp_drop)); end
  endtask

  task automatic test_runt();
    bit ok; int nbad = 0;
    apply_reset();
    send_pkt(2, 1'b1, 0, 4'd0);
    send_pkt(5, 1'b1, 0, 4'd3);
    drain(200, ok);
    checks++; if (!ok || got_q.size() != 4) begin errors++;
      $display("FAIL runt_count: got %0d words expected 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL runt_words: got %0d bad expected 0", nbad); end
    checks++; if (vcnt != 1 || vbad != 0) begin errors++;
      $display("FAIL runt_valid: got %0d strobes (%0d misplaced) expected 1", vcnt, vbad); end
    checks++; if (s_runt !== stat_exp(exp_runt) || s_fwd !== stat_exp(exp_fwd)) begin errors++;
      $display("FAIL runt_stat: got %0d/%0d expected %0d/%0d", s_runt, s_fwd, stat_exp(exp_runt), stat_exp(exp_fwd)); end
  endtask

  task automatic test_random();
    bit ok; int nbad = 0, n;
    apply_reset();
    for (int p = 0; p < 40; p++) begin
      ds_af = ($urandom_range(0, 3) == 0);
      n = 0;
      while (af && n < 500) begin @(posedge clk); n++; end
      send_pkt($urandom_range(1, 9), ($urandom_range(0, 3) != 0), $urandom_range(0, 2), BW'($urandom));
    end
    ds_af = 1'b0;
    drain(3000, ok);
    checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rnd_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL rnd_words: got %0d bad expected 0", nbad); end
    checks++; if (vcnt != exp_vcnt || vbad != 0) begin errors++;
      $display("FAIL rnd_valid: got %0d strobes (%0d misplaced) expected %0d", vcnt, vbad, exp_vcnt); end
    checks++; if (s_fwd !== stat_exp(exp_fwd) || s_drop !== stat_exp(exp_drop) || s_runt !== stat_exp(exp_runt)) begin
      errors++; $display("FAIL rnd_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", s_fwd, s_drop, s_runt,
                         stat_exp(exp_fwd), stat_exp(exp_drop), stat_exp(exp_runt)); end
  endtask

  task automatic test_almostfull();
    logic [PW-1:0] w[$];
    bit ok; int nbad = 0, gap_bad = 0;
    apply_reset();
    ds_af = 1'b1;
    for (int p = 0; p < 30; p++) begin
      w.delete();
      for (int i = 0; i < 8; i++) w.push_back(mk_word(i, 8, BW'($urandom)));
      for (int i = 0; i < 8; i++) begin
        if (p == 29 && i == 7) begin
          @(posedge clk); #1; pkt_wr = 1'b0; vwr = 1'b0;
          @(posedge clk); @(negedge clk);
          checks++; if (af !== 1'b0) begin errors++; $display("FAIL af_at_239: got %b expected 0", af); end
        end
        @(posedge clk); #1;
        pkt_wr = 1'b1; pkt = w[i]; vwr = (i == 7); vld = 1'b1;
      end
      model_pkt(w, 1'b1);
    end
    @(posedge clk); #1; pkt_wr = 1'b0; vwr = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (af !== 1'b1) begin errors++; $display("FAIL af_at_240: got %b expected 1", af); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL af_hold: got %0d words expected 0", got_q.size()); end
    ds_af = 1'b0;
    drain(2000, ok);
    checks++; if (!ok || got_q.size() != 210) begin errors++;
      $display("FAIL af_drain_count: got %0d words expected 210", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL af_drain_words: got %0d bad expected 0", nbad); end
    if (got_cyc.size() >= 210)
      for (int p = 1; p < 30; p++) if (got_cyc[p*7] - got_cyc[(p-1)*7] != 10) gap_bad++;
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL af_back_to_back: got %0d bad gaps expected 0", gap_bad); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL af_release: got %b expected 0", af); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0, nbad = 0, held;
    apply_reset();
    send_pkt(6, 1'b1, 0, 4'd2);
    while (got_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rmid_wait: got %0d words expected 2", got_q.size()); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({o_wr, o_vwr, o_v, af} !== 4'b0 || o_pkt !== '0) begin errors++;
      $display("FAIL rmid_outputs: got %b pkt %h expected 0", {o_wr, o_vwr, o_v, af}, o_pkt); end
    checks++; if (u_dut.d_used !== '0 || u_dut.v_used !== '0) begin errors++;
      $display("FAIL rmid_fifos: got %0d/%0d expected 0/0", u_dut.d_used, u_dut.v_used); end
    @(posedge clk); #1; reset = 1'b0;
    held = got_q.size();
    repeat (20) @(negedge clk);
    checks++; if (vcnt != 0 || got_q.size() != held) begin errors++;
      $display("FAIL rmid_quiet: got %0d strobes %0d words expected 0 0", vcnt, got_q.size() - held); end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    vcnt = 0; vbad = 0; exp_vcnt = 0; exp_fwd = 0; exp_drop = 0; exp_runt = 0;
    send_pkt(5, 1'b1, 1, 4'd7);
    drain(200, ok);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
    checks++; if (!ok || got_q.size() != 4 || nbad != 0) begin errors++;
      $display("FAIL rmid_after: got %0d words (%0d bad) expected 4", got_q.size(), nbad); end
    checks++; if (vcnt != 1 || vbad != 0) begin errors++;
      $display("FAIL rmid_after_valid: got %0d strobes expected 1", vcnt); end
  endtask

  task automatic test_meta0_w64();
    logic [PWB-1:0] w[3];
    int n = 0, nbad = 0;
    apply_reset();
    for (int i = 0; i < 3; i++)
      w[i] = {(i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b11, (i == 2) ? 3'($urandom) : 3'd0, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      b_pkt_wr = 1'b1; b_pkt = w[i]; b_vwr = (i == 2); b_vld = 1'b1;
    end
    @(posedge clk); #1; b_pkt_wr = 1'b0; b_vwr = 1'b0;
    while ((b_got.size() < 3 || b_vcnt < 1) && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (b_got.size() != 3) begin errors++; $display("FAIL m0_count: got %0d expected 3", b_got.size()); end
    for (int i = 0; i < 3 && i < b_got.size(); i++) if (b_got[i] !== w[i]) nbad++;
    checks++; if (nbad != 0) begin errors++; $display("FAIL m0_words: got %0d bad expected 0", nbad); end
    checks++; if (b_vcnt != 1) begin errors++; $display("FAIL m0_valid: got %0d expected 1", b_vcnt); end
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_drop();
    test_runt();
    test_random();
    test_almostfull();
    test_reset_mid();
    test_meta0_w64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
